// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling FSM, byte holding
// register with valid/ack handshake, framing-error pulse and sticky overrun flag.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             cnt_bit_end;

  assign rx_s        = rx_p1;
  assign busy        = (state != IDLE);
  assign cnt_bit_end = (cnt == CNT_BIT_END);

  // Stage p0/p1: synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // Frame FSM and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (data_ack && data_valid)
        data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              // A coincident ack frees the register, so the new byte is not an overrun
              data       <= shift;
              data_valid <= 1'b1;
              if (data_valid && !data_ack)
                overrun <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register holds only in-flight data bits, so it needs no reset
  always_ff @(posedge clk) begin
    if (state == DATA && cnt_bit_end)
      shift[bit_idx] <= rx_s;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed vector table, hand-written corner sequences,
// and random frames checked against a transaction-level model.
module tb_uart_receiver;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  // Stop bit sampled by the edge that ends loop iteration 154 (2 sync + half bit + 9 bits)
  localparam int STOP_ITER = 154;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_total = 0;
  int busy_cycles = 0;
  logic pre_dv;
  logic post_dv;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ack(data_ack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_total++;
    if (busy === 1'b1) busy_cycles++;
  end

  typedef struct {
    logic [7:0] b;
    bit         stopb;
    bit         coinc;
    bit         ack_after;
    bit         exp_pre;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ov;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stopb, input int ack_cycle,
                            input int n_iter);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    for (int i = 0; i < n_iter; i++) begin
      rx       = bits[i / CPB];
      data_ack = (i == ack_cycle);
      @(posedge clk);
      #1;
      if (i == STOP_ITER - 1) pre_dv = data_valid;
      if (i == STOP_ITER) post_dv = data_valid;
    end
    data_ack = 1'b0;
  endtask

  task automatic release_break(input int hold);
    tick(hold);
    check("break_busy_held", busy, 1'b1);
    rx = 1'b1;
    tick(4);
    check("break_busy_released", busy, 1'b0);
  endtask

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ov;

  initial begin
    int fe0;
    int bc0;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 0};

    // Reset state
    tick(3);
    rst = 1'b0;
    check("rst_data", data, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick(4);

    // Short low glitch: start check lasts half a bit, then back to IDLE
    fe0 = fe_total;
    bc0 = busy_cycles;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    check("glitch_busy_cycles", busy_cycles - bc0, CPB / 2);
    check("glitch_busy_idle", busy, 1'b0);
    check("glitch_valid", data_valid, 1'b0);
    check("glitch_frame_err", fe_total - fe0, 0);

    // Ack while nothing held is ignored
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
    check("idle_ack_valid", data_valid, 1'b0);

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      fe0 = fe_total;
      send_frame(vecs[v].b, vecs[v].stopb, vecs[v].coinc ? STOP_ITER : -1, FRAME);
      check($sformatf("vec%0d_pre_valid", v), pre_dv, vecs[v].exp_pre);
      check($sformatf("vec%0d_post_valid", v), post_dv, vecs[v].exp_valid);
      if (!vecs[v].stopb) release_break(40);
      check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
      check($sformatf("vec%0d_valid", v), data_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_overrun", v), overrun, vecs[v].exp_ov);
      check($sformatf("vec%0d_frame_err", v), fe_total - fe0, vecs[v].exp_fe);
      if (vecs[v].ack_after) begin
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        check($sformatf("vec%0d_ack_clears", v), data_valid, 1'b0);
      end
    end

    // Reset in the middle of data bit 4 of 0x81
    send_frame(8'h81, 1'b1, -1, 5 * CPB + CPB / 2);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    tick(1);
    check("midrst_data", data, 8'h00);
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    tick(5);
    fe0 = fe_total;
    send_frame(8'h81, 1'b1, -1, FRAME);
    check("after_rst_data", data, 8'h81);
    check("after_rst_valid", data_valid, 1'b1);
    check("after_rst_overrun", overrun, 1'b0);
    check("after_rst_frame_err", fe_total - fe0, 0);

    // Random frames against a transaction-level model
    m_data  = 8'h81;
    m_valid = 1'b1;
    m_ov    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      bit         stopb;
      int         mode;
      int         exp_fe;
      b      = 8'($urandom_range(0, 255));
      stopb  = ($urandom_range(0, 5) != 0);
      mode   = $urandom_range(0, 2);
      exp_fe = 0;
      rx = 1'b1;
      tick($urandom_range(0, 3));
      fe0 = fe_total;
      send_frame(b, stopb, (mode == 1) ? STOP_ITER : -1, FRAME);
      if (stopb) begin
        if (m_valid && mode != 1) m_ov = 1'b1;
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        exp_fe = 1;
        release_break($urandom_range(1, 20));
      end
      check($sformatf("rnd%0d_data", k), data, m_data);
      check($sformatf("rnd%0d_valid", k), data_valid, m_valid);
      check($sformatf("rnd%0d_overrun", k), overrun, m_ov);
      check($sformatf("rnd%0d_frame_err", k), fe_total - fe0, exp_fe);
      if (mode == 2) begin
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        m_valid = 1'b0;
        check($sformatf("rnd%0d_ack", k), data_valid, m_valid);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
